// File: rtl/mix_digest.sv
// mix_digest: folds a 256-bit eight-lane snapshot into a running 32-bit digest, one lane per cycle.
// Defining MIX_DIGEST_CLEAR_EN adds a synchronous active-high `clear` input.
module mix_digest #(
    parameter logic [31:0] SEED = 32'h0000_0000,
    parameter int unsigned ROT  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef MIX_DIGEST_CLEAR_EN
    input  logic         clear,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic         digest_valid,
    output logic [31:0]  digest,
    output logic [15:0]  block_count
);

    typedef enum logic {
        ST_IDLE,
        ST_FOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] lane_q [8];
    logic [31:0] lane_d [8];
    logic [2:0]  idx_q, idx_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] digest_q, digest_d;
    logic        digest_valid_q, digest_valid_d;
    logic [15:0] block_count_q, block_count_d;
    logic        clear_w;
    logic [31:0] fold_w;

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << ROT) | (x >> (32 - ROT));
    endfunction

`ifdef MIX_DIGEST_CLEAR_EN
    assign clear_w = clear;
`else
    assign clear_w = 1'b0;
`endif

    assign fold_w = rotl(acc_q) ^ lane_q[idx_q];

    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;
        block_count_d  = block_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        lane_d[i] = in_data[32*i +: 32];
                    end
                    idx_d   = '0;
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                acc_d = fold_w;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    digest_d       = fold_w;
                    digest_valid_d = 1'b1;
                    block_count_d  = block_count_q + 16'd1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // clear overrides both a same-cycle handshake and the final fold step
        if (clear_w) begin
            state_d        = ST_IDLE;
            lane_d         = lane_q;
            idx_d          = '0;
            acc_d          = SEED;
            digest_d       = '0;
            digest_valid_d = 1'b0;
            block_count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            for (int unsigned i = 0; i < 8; i++) begin
                lane_q[i] <= '0;
            end
            idx_q          <= '0;
            acc_q          <= SEED;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            block_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            block_count_q  <= block_count_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign digest_valid = digest_valid_q;
    assign digest       = digest_q;
    assign block_count  = block_count_q;

endmodule

// File: tb/tb_mix_digest.sv
// Self-checking bench for mix_digest: table vectors, abort/clear sequences, and randomized blocks
// checked against a lane-by-lane arithmetic model of the running digest for three parameter sets.
module tb_mix_digest;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [255:0] in_data;
`ifdef MIX_DIGEST_CLEAR_EN
    logic         clear;
`endif
    logic         in_ready     [N];
    logic         digest_valid [N];
    logic [31:0]  digest       [N];
    logic [15:0]  block_count  [N];

    logic [31:0]  m_seed [N] = '{32'h0000_0000, 32'h8000_0000, 32'h1234_5678};
    int unsigned  m_rot  [N] = '{1, 1, 13};
    logic [31:0]  m_acc  [N];
    logic [15:0]  m_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mix_digest #(.SEED(32'h0000_0000), .ROT(1)) u_base (
        .clk(clk), .rst_n(rst_n),
`ifdef MIX_DIGEST_CLEAR_EN
        .clear(clear),
`endif
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .digest_valid(digest_valid[0]), .digest(digest[0]), .block_count(block_count[0])
    );

    mix_digest #(.SEED(32'h8000_0000), .ROT(1)) u_wrap (
        .clk(clk), .rst_n(rst_n),
`ifdef MIX_DIGEST_CLEAR_EN
        .clear(clear),
`endif
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .digest_valid(digest_valid[1]), .digest(digest[1]), .block_count(block_count[1])
    );

    mix_digest #(.SEED(32'h1234_5678), .ROT(13)) u_rot (
        .clk(clk), .rst_n(rst_n),
`ifdef MIX_DIGEST_CLEAR_EN
        .clear(clear),
`endif
        .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
        .digest_valid(digest_valid[2]), .digest(digest[2]), .block_count(block_count[2])
    );

    typedef struct {
        logic [255:0] data;
        logic [31:0]  exp_digest;
        logic [15:0]  exp_count;
    } vec_t;

    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int unsigned r);
        logic [63:0] dbl;
        dbl = {x, x};
        return dbl[63 - r -: 32];
    endfunction

    function automatic logic [31:0] ref_fold(input logic [31:0] acc, input logic [255:0] d,
                                             input int unsigned r);
        logic [31:0] a;
        a = acc;
        for (int i = 0; i < 8; i++) a = ref_rotl(a, r) ^ d[32*i +: 32];
        return a;
    endfunction

    function automatic logic [255:0] rand_lanes();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) m_acc[j] = m_seed[j];
        m_cnt = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int j = 0; j < N; j++) begin
            check({tag, "_ready"},  {31'd0, in_ready[j]}, 32'd1);
            check({tag, "_valid"},  {31'd0, digest_valid[j]}, 32'd0);
            check({tag, "_digest"}, digest[j], 32'd0);
            check({tag, "_count"},  {16'd0, block_count[j]}, 32'd0);
        end
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = rand_lanes();
`ifdef MIX_DIGEST_CLEAR_EN
        clear    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // abort_at: 0 = none, else the fold edge after which the block is aborted
    task automatic do_block(input logic [255:0] d, input bit hold, input int abort_at,
                            input bit by_clear);
        int  w;
        bit  bad;
        w = 0;
        @(negedge clk);
        while (!in_ready[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready[0]) begin
            check("ready_wait_timeout", {31'd0, in_ready[0]}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = hold;
        if (hold) in_data = rand_lanes();
        bad = 1'b0;
        for (int j = 0; j < N; j++) if (in_ready[j] !== 1'b0 || digest_valid[j] !== 1'b0) bad = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (hold) in_data = rand_lanes();
            for (int j = 0; j < N; j++)
                if (in_ready[j] !== 1'b0 || digest_valid[j] !== 1'b0) bad = 1'b1;
            if (k == abort_at) begin
                check("busy_ready_valid", {31'd0, bad}, 32'd0);
                in_valid = 1'b0;
                if (by_clear) begin
`ifdef MIX_DIGEST_CLEAR_EN
                    clear = 1'b1;
                    @(negedge clk);
                    clear = 1'b0;
                    check_reset_vals("clear_abort");
                    @(negedge clk);
                    check("clear_no_late_pulse", {31'd0, digest_valid[0]}, 32'd0);
                    model_reset();
`endif
                end else begin
                    rst_n = 1'b0;
                    #1;
                    check_reset_vals("rst_abort");
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    model_reset();
                    @(negedge clk);
                    check("rst_no_late_pulse", {31'd0, digest_valid[0]}, 32'd0);
                end
                return;
            end
        end
        check("busy_ready_valid", {31'd0, bad}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        m_cnt = m_cnt + 16'd1;
        for (int j = 0; j < N; j++) begin
            m_acc[j] = ref_fold(m_acc[j], d, m_rot[j]);
            check("done_valid",  {31'd0, digest_valid[j]}, 32'd1);
            check("done_ready",  {31'd0, in_ready[j]}, 32'd1);
            check("done_digest", digest[j], m_acc[j]);
            check("done_count",  {16'd0, block_count[j]}, {16'd0, m_cnt});
        end
        @(negedge clk);
        check("pulse_one_cycle", {31'd0, digest_valid[0]}, 32'd0);
        check("digest_hold", digest[0], m_acc[0]);
    endtask

    vec_t         tbl [4];
    logic [255:0] seq_data;

    initial begin
        for (int i = 0; i < 8; i++) seq_data[32*i +: 32] = 32'(i + 1);
        tbl[0] = '{seq_data,   32'h0000_0016, 16'd1};
        tbl[1] = '{256'd0,     32'h0000_1600, 16'd2};
        tbl[2] = '{'1,         32'h0016_0000, 16'd3};
        tbl[3] = '{256'd1,     32'h1600_0080, 16'd4};

        reset_dut();
        check_reset_vals("reset");

        for (int t = 0; t < 4; t++) begin
            do_block(tbl[t].data, 1'b0, 0, 1'b0);
            check($sformatf("tbl%0d_digest", t), digest[0], tbl[t].exp_digest);
            check($sformatf("tbl%0d_count", t), {16'd0, block_count[0]}, {16'd0, tbl[t].exp_count});
        end

        reset_dut();
        do_block(256'd0, 1'b0, 0, 1'b0);
        check("rot_wrap_digest", digest[1], 32'h0000_0080);

        do_block(seq_data, 1'b0, 3, 1'b0);
        do_block(seq_data, 1'b1, 0, 1'b0);
        check("hold_valid_digest", digest[0], 32'h0000_0016);
        check("hold_valid_count", {16'd0, block_count[0]}, 32'd1);

`ifdef MIX_DIGEST_CLEAR_EN
        do_block(seq_data, 1'b0, 7, 1'b1);
        check("after_clear_count", {16'd0, block_count[0]}, 32'd0);
        do_block(seq_data, 1'b0, 0, 1'b0);
        check("post_clear_digest", digest[0], 32'h0000_0016);
        check("post_clear_count", {16'd0, block_count[0]}, 32'd1);
`endif

        for (int r = 0; r < 24; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_block(rand_lanes(), 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
